// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order fetch responses after a fixed latency, with flush.
// Optional IMEM_MISALIGN_CHECK_EN adds rsp_fault and replaces misaligned fetches with a nop.
module imem_responder #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [95:0] rsp_bus_info
`ifdef IMEM_MISALIGN_CHECK_EN
  ,
  output logic        rsp_fault
`endif
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [3:0]    LAT  = 4'(LATENCY);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  logic [63:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [3:0]       age_q   [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [DEPTH-1:0] occupied;
  logic             push;
  logic             pop;
  logic [31:0]      instr_new;
`ifdef IMEM_MISALIGN_CHECK_EN
  logic             fault_q [DEPTH];
  logic             fault_new;
`endif

  // Behavioural instruction memory sampled at accept time: a short boot program, then a fill pattern.
  function automatic logic [31:0] dpi_instr_mem_read(input logic [63:0] addr);
    logic [31:0] word;
    word = addr[31:0] ^ 32'h1357_9BDF;
    if (addr[63:4] == 60'h800_0000) begin
      case (addr[3:2])
        2'd0:    word = 32'h0000_0297;
        2'd1:    word = 32'h0202_8593;
        2'd2:    word = 32'h0005_a503;
        default: word = 32'h00a5_8633;
      endcase
    end
    return word;
  endfunction

  assign req_ready = rst_n && (count != FULL);
  assign rsp_valid = (count != '0) && (age_q[rd_ptr] >= LAT);
  assign push      = req_valid && req_ready && !flush;
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign rsp_bus_info = rsp_valid ? {pc_q[rd_ptr], instr_q[rd_ptr]} : '0;
`ifdef IMEM_MISALIGN_CHECK_EN
  assign rsp_fault = rsp_valid && fault_q[rd_ptr];
`endif

  // An entry is live when its distance from the head is below count.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = {1'b0, PW'(i) - rd_ptr} < count;
    end
  end

  always_comb begin
    instr_new = '0;
`ifdef IMEM_MISALIGN_CHECK_EN
    fault_new = 1'b0;
    if (push) begin
      if (req_addr[1:0] != 2'b00) begin
        fault_new = 1'b1;
        instr_new = NOP;
      end else begin
        instr_new = dpi_instr_mem_read(req_addr);
      end
    end
`else
    if (push) begin
      instr_new = dpi_instr_mem_read(req_addr);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occupied[i] && (age_q[i] < LAT)) begin
          age_q[i] <= age_q[i] + 4'd1;
        end
      end
      if (push) begin
        age_q[wr_ptr] <= 4'd1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is carried by count and age.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= req_addr;
      instr_q[wr_ptr] <= instr_new;
`ifdef IMEM_MISALIGN_CHECK_EN
      fault_q[wr_ptr] <= fault_new;
`endif
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY=1 and LATENCY=3) driven by directed steps with a scoreboard.
// Exercises the misaligned-fetch path when IMEM_MISALIGN_CHECK_EN is defined.
module tb_imem_responder;

  logic        clk;
  logic        rst_n;
  logic        flush_a, req_valid_a, rsp_ready_a, req_ready_a, rsp_valid_a, rsp_fault_a;
  logic        flush_b, req_valid_b, rsp_ready_b, req_ready_b, rsp_valid_b, rsp_fault_b;
  logic [63:0] req_addr_a, req_addr_b;
  logic [95:0] rsp_bus_info_a, rsp_bus_info_b;

  logic [96:0] q_a[$];
  logic [96:0] q_b[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  imem_responder #(.LATENCY(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_bus_info(rsp_bus_info_a)
`ifdef IMEM_MISALIGN_CHECK_EN
    , .rsp_fault(rsp_fault_a)
`endif
  );

  imem_responder #(.LATENCY(3), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_bus_info(rsp_bus_info_b)
`ifdef IMEM_MISALIGN_CHECK_EN
    , .rsp_fault(rsp_fault_b)
`endif
  );

`ifndef IMEM_MISALIGN_CHECK_EN
  assign rsp_fault_a = 1'b0;
  assign rsp_fault_b = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory contents and the entry a fetch of addr should return: {fault, pc, instr}.
  function automatic logic [96:0] expect_entry(input logic [63:0] addr);
    logic [31:0] w;
    w = addr[31:0] ^ 32'h1357_9BDF;
    if (addr[63:4] == 60'h800_0000) begin
      case (addr[3:2])
        2'd0:    w = 32'h0000_0297;
        2'd1:    w = 32'h0202_8593;
        2'd2:    w = 32'h0005_a503;
        default: w = 32'h00a5_8633;
      endcase
    end
`ifdef IMEM_MISALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) return {1'b1, addr, 32'h0000_0013};
`endif
    return {1'b0, addr, w};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_head_a(input logic [96:0] got);
    n_checks++;
    assert (q_a.size() != 0) else begin
      n_fail++;
      $error("[TB] FAIL sb_a_unexpected observed=%h expected=none", got);
    end
    if (q_a.size() != 0) check_output("sb_a", {31'b0, got}, {31'b0, q_a.pop_front()});
  endtask

  task automatic check_head_b(input logic [96:0] got);
    n_checks++;
    assert (q_b.size() != 0) else begin
      n_fail++;
      $error("[TB] FAIL sb_b_unexpected observed=%h expected=none", got);
    end
    if (q_b.size() != 0) check_output("sb_b", {31'b0, got}, {31'b0, q_b.pop_front()});
  endtask

  // Drive one cycle on the selected instance (0 = A, 1 = B), update the scoreboard, then advance.
  task automatic apply_stimulus(input bit sel, input bit v, input logic [63:0] addr, input bit rr, input bit fl);
    req_valid_a = 1'b0; rsp_ready_a = 1'b0; flush_a = 1'b0; req_addr_a = '0;
    req_valid_b = 1'b0; rsp_ready_b = 1'b0; flush_b = 1'b0; req_addr_b = '0;
    if (!sel) begin
      req_valid_a = v; req_addr_a = addr; rsp_ready_a = rr; flush_a = fl;
    end else begin
      req_valid_b = v; req_addr_b = addr; rsp_ready_b = rr; flush_b = fl;
    end
    #1;
    if (!sel) begin
      if (fl) q_a.delete();
      else begin
        if (rsp_valid_a && rsp_ready_a) check_head_a({rsp_fault_a, rsp_bus_info_a});
        if (req_valid_a && req_ready_a) q_a.push_back(expect_entry(addr));
      end
    end else begin
      if (fl) q_b.delete();
      else begin
        if (rsp_valid_b && rsp_ready_b) check_head_b({rsp_fault_b, rsp_bus_info_b});
        if (req_valid_b && req_ready_b) q_b.push_back(expect_entry(addr));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid_a = 1'b0; rsp_ready_a = 1'b0; flush_a = 1'b0; req_addr_a = '0;
    req_valid_b = 1'b0; rsp_ready_b = 1'b0; flush_b = 1'b0; req_addr_b = '0;
    #1 rst_n = 1'b0;
    #2;
    check_output("rst_req_ready", req_ready_a, 0);
    check_output("rst_rsp_valid", rsp_valid_b, 0);
    check_output("rst_bus", rsp_bus_info_a, 0);
    check_output("rst_fault", rsp_fault_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("release_req_ready", {req_ready_a, req_ready_b}, 2'b11);
    @(negedge clk);

    $display("[TB] single request, LATENCY=1");
    apply_stimulus(0, 1, 64'h8000_0000, 1, 0);
    check_output("l1_valid", rsp_valid_a, 1);
    check_output("l1_bus", rsp_bus_info_a, {64'h8000_0000, 32'h0000_0297});
    apply_stimulus(0, 0, 64'h0, 1, 0);
    check_output("l1_drop", rsp_valid_a, 0);

    $display("[TB] fill to full, LATENCY=3");
    for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 64'h8000_0000 + 64'(4 * i), 0, 0);
    check_output("full_req_ready", req_ready_b, 0);
    check_output("full_rsp_valid", rsp_valid_b, 1);
    apply_stimulus(1, 1, 64'h8000_0010, 0, 0);
    check_output("hold_bus", rsp_bus_info_b, {64'h8000_0000, 32'h0000_0297});
    check_output("hold_valid", rsp_valid_b, 1);
    apply_stimulus(1, 0, 64'h0, 1, 0);
    check_output("ready_after_pop", req_ready_b, 1);
    for (int i = 0; i < 3; i++) begin
      check_output("drain_valid", rsp_valid_b, 1);
      apply_stimulus(1, 0, 64'h0, 1, 0);
    end
    check_output("drain_done", rsp_valid_b, 0);
    check_output("drain_queue", q_b.size(), 0);

    $display("[TB] steady stream, LATENCY=3");
    for (int i = 0; i < 12; i++) begin
      if (i >= 3) begin
        check_output("stream_valid", rsp_valid_b, 1);
        check_output("stream_ready", req_ready_b, 1);
      end
      apply_stimulus(1, 1, 64'h8000_0100 + 64'(4 * i), 1, 0);
    end
    for (int i = 0; i < 10 && q_b.size() != 0; i++) apply_stimulus(1, 0, 64'h0, 1, 0);
    check_output("stream_queue", q_b.size(), 0);

    $display("[TB] flush with 3 outstanding");
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 64'h8000_0200 + 64'(4 * i), 0, 0);
    apply_stimulus(1, 1, 64'h8000_0300, 1, 1);
    check_output("flush_valid", rsp_valid_b, 0);
    check_output("flush_ready", req_ready_b, 1);
    apply_stimulus(1, 1, 64'h8000_0004, 1, 0);
    check_output("post_flush_c1", rsp_valid_b, 0);
    apply_stimulus(1, 0, 64'h0, 1, 0);
    check_output("post_flush_c2", rsp_valid_b, 0);
    apply_stimulus(1, 0, 64'h0, 1, 0);
    check_output("post_flush_c3", rsp_valid_b, 1);
    check_output("post_flush_bus", rsp_bus_info_b, {64'h8000_0004, 32'h0202_8593});
    apply_stimulus(1, 0, 64'h0, 1, 0);
    check_output("post_flush_queue", q_b.size(), 0);

    $display("[TB] asynchronous reset mid-stream");
    apply_stimulus(0, 1, 64'h8000_0008, 0, 0);
    apply_stimulus(0, 1, 64'h8000_000C, 0, 0);
    check_output("pre_reset_valid", rsp_valid_a, 1);
    req_valid_a = 1'b0; rsp_ready_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("async_valid", rsp_valid_a, 0);
    check_output("async_bus", rsp_bus_info_a, 0);
    check_output("async_ready", req_ready_a, 0);
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("post_reset_valid", rsp_valid_a, 0);
    apply_stimulus(0, 0, 64'h0, 1, 0);
    check_output("post_reset_idle", rsp_valid_a, 0);
    apply_stimulus(0, 1, 64'h8000_000C, 1, 0);
    check_output("post_reset_rsp", rsp_valid_a, 1);
    check_output("post_reset_bus", rsp_bus_info_a, {64'h8000_000C, 32'h00a5_8633});
    apply_stimulus(0, 0, 64'h0, 1, 0);

    $display("[TB] misaligned fetch");
    apply_stimulus(0, 1, 64'h8000_0002, 1, 0);
    check_output("mis_valid", rsp_valid_a, 1);
`ifdef IMEM_MISALIGN_CHECK_EN
    check_output("mis_fault", rsp_fault_a, 1);
    check_output("mis_bus", rsp_bus_info_a, {64'h8000_0002, 32'h0000_0013});
`else
    check_output("mis_bus", rsp_bus_info_a, {64'h8000_0002, 32'h0000_0297});
`endif
    apply_stimulus(0, 1, 64'h8000_0004, 1, 0);
    check_output("aligned_fault", rsp_fault_a, 0);
    check_output("aligned_bus", rsp_bus_info_a, {64'h8000_0004, 32'h0202_8593});
    apply_stimulus(0, 0, 64'h0, 1, 0);
    check_output("final_queue_a", q_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the far side of the fetch request path.
- Accepts PC fetch requests over a valid/ready channel and reads the 32-bit instruction word through DPI `dpi_instr_mem_read` at the moment a request is accepted.
- Returns `{pc, instr}` on a 96-bit response channel, in order, after a fixed programmable latency.
- Buffers up to DEPTH outstanding requests, so the fetch stage can pipeline requests and apply back-pressure; supports flush on redirect.

Parameters:
- LATENCY, 1, cycles from request acceptance to earliest `rsp_valid`; legal range 1..15.
- DEPTH, 4, outstanding-entry capacity; power of 2, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  discard all outstanding entries (pipeline redirect).
- req_valid  input  1  fetch request valid.
- req_ready  output  1  responder can accept a request.
- req_addr  input  64  fetch PC.
- rsp_valid  output  1  head response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_bus_info  output  96  `{pc[63:0], instr[31:0]}`.
- rsp_fault  output  1  misaligned-PC flag; present only with IMEM_MISALIGN_CHECK_EN.

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding pc, instr, age (4 bits) and, when the feature is enabled, fault.
  - Read and write pointers are log2(DEPTH) bits wide and wrap naturally.
  - `count` is log2(DEPTH)+1 bits wide.
- Reset (rst_n low, asynchronous): pointers=0, count=0, all ages=0.
  - Outputs while in reset and immediately after: `rsp_valid`=0, `rsp_bus_info`=0, `rsp_fault`=0, `req_ready`=0.
  - `req_ready` rises in the first cycle after rst_n is released.
- `req_ready` = rst_n && (count != DEPTH).
  - Purely from registered count; a pop in the same cycle does not free a slot.
- Push: occurs when `req_valid && req_ready && !flush`.
  - DPI read of `req_addr` is performed in that cycle.
  - Entry written with pc=`req_addr`, instr=DPI result, age=1.
- Aging: every cycle, each occupied entry with age < LATENCY increments its age. Age saturates at LATENCY.
- Response: `rsp_valid` = (count != 0) && (head age >= LATENCY).
  - `rsp_bus_info` = head `{pc, instr}` when `rsp_valid`, otherwise 96'b0.
  - LATENCY=1: `rsp_valid` in the cycle immediately after the accept edge.
  - LATENCY=N: `rsp_valid` N cycles after the accept edge.
- Pop: occurs when `rsp_valid && rsp_ready && !flush`.
  - Head advances; the next entry becomes visible the following cycle if its own age already satisfies LATENCY.
  - Back-to-back streaming gives 1 response per cycle.
- Hold rule: while `rsp_valid && !rsp_ready`, `rsp_bus_info` stays stable and `rsp_valid` stays high.
- Simultaneous push and pop in the same cycle: both take effect; count is unchanged.
- Full (count==DEPTH): `req_ready`=0 and requests stall. Entries already stored are never overwritten.
- Empty: `rsp_valid`=0. A request arriving while empty follows the exact LATENCY timing; there is no bypass.
- Flush: synchronous, highest priority.
  - Next cycle: pointers=0, count=0, `rsp_valid`=0.
  - The request and response presented in the flush cycle are both dropped; no DPI read occurs for the dropped request.
- Ordering: responses are returned strictly in request order.

Optional Feature:
- IMEM_MISALIGN_CHECK_EN.
- Defined:
  - Port `rsp_fault` exists.
  - A push with `req_addr[1:0] != 0` skips the DPI read, stores instr=32'h00000013 (nop), and sets fault=1.
  - `rsp_fault` = head fault when `rsp_valid`, otherwise 0.
  - The faulting entry obeys the same latency and ordering as any other entry.
- Undefined:
  - No `rsp_fault` port.
  - Every address is passed to DPI unmodified.

Test Plan:
- LATENCY=1: single request addr=0x80000000 (mem word 0x00000297), `rsp_ready`=1 -> `rsp_valid` exactly 1 cycle after accept; `rsp_bus_info`={0x80000000, 0x00000297}; `rsp_valid` drops the next cycle.
- LATENCY=3, DEPTH=4: push 0x80000000..0x8000000C on 4 consecutive cycles with `rsp_ready`=0 -> `req_ready`=0 after the 4th push. Then set `rsp_ready`=1 -> 4 responses in order on consecutive cycles; `req_ready` returns to 1 one cycle after the first pop.
- Steady stream with `req_valid`=`rsp_ready`=1, LATENCY=2 -> after fill, one response per cycle, count constant at 2, no bubbles.
- Flush asserted with 3 entries outstanding while `req_valid`=1 -> next cycle `rsp_valid`=0 and count=0; the flushed request never appears; a new request issued afterwards returns after exactly LATENCY cycles.
- rst_n pulsed low mid-stream with 2 entries valid -> outputs go to 0 asynchronously; after release `rsp_valid` stays 0 until a new request ages LATENCY cycles.
- With IMEM_MISALIGN_CHECK_EN: request 0x80000002 -> response pc=0x80000002, instr=0x00000013, `rsp_fault`=1. The following aligned request returns with `rsp_fault`=0.
